// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: one shared multiply-accumulate per clock over TAPS taps.
// Define FIR_TAP_SEQUENCER_SAT_EN to saturate each accumulate step instead of wrapping.
module fir_tap_sequencer #(
    parameter int DATA_W = 2,
    parameter int COEF_W = 4,
    parameter int TAPS   = 8,
    parameter int ACC_W  = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              cfg_err,
    output logic              busy
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] tap  [TAPS];
    logic [COEF_W-1:0] coef [TAPS];
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [ADDR_W-1:0] k;
    logic [PROD_W-1:0] product;

    // Full-width product so no bits are lost before the accumulate step.
    always_comb begin
        product = PROD_W'(coef[k]) * PROD_W'(tap[k]);
    end

`ifdef FIR_TAP_SEQUENCER_SAT_EN
    logic [SUM_W-1:0] sum_full;

    always_comb begin
        sum_full = SUM_W'(acc) + SUM_W'(product);
        if (sum_full > SUM_W'({ACC_W{1'b1}})) begin
            acc_next = {ACC_W{1'b1}};
        end else begin
            acc_next = sum_full[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        acc_next = ACC_W'(SUM_W'(acc) + SUM_W'(product));
    end
`endif

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        busy       = (state != IDLE);
        unique case (state)
            IDLE:    if (in_valid) state_next = ACCUM;
            ACCUM:   if (k == LAST_TAP) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the coefficient table is reset on purpose; it must come up holding 1..TAPS, not just zeros.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                tap[i]  <= '0;
                coef[i] <= COEF_W'(i + 1);
            end
            acc       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && (state != IDLE);
            // Config writes only land while idle, including on an accept edge.
            if (cfg_we && (state == IDLE)) begin
                coef[cfg_addr] <= cfg_data;
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        tap[0] <= x;
                        for (int i = 1; i < TAPS; i++) begin
                            tap[i] <= tap[i-1];
                        end
                        acc <= '0;
                        k   <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    k   <= k + ADDR_W'(1);
                    if (k == LAST_TAP) begin
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: a reference model pushes expected results to a
// scoreboard queue on each accepted sample; results are popped and compared when out_valid rises.
module tb_fir_tap_sequencer;

    localparam int DATA_W  = 2;
    localparam int COEF_W  = 4;
    localparam int TAPS    = 8;
    localparam int ACC_W   = 4;
    localparam int ADDR_W  = 3;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [COEF_W-1:0] cfg_data;
    logic              cfg_err;
    logic              busy;

    fir_tap_sequencer #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .TAPS  (TAPS),
        .ACC_W (ACC_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int accept_cyc = 0;
    int last_exp = 0;
    int sb [$];

    logic [DATA_W-1:0] m_tap  [TAPS];
    logic [COEF_W-1:0] m_coef [TAPS];

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            m_tap[i]  = '0;
            m_coef[i] = COEF_W'(i + 1);
        end
        sb.delete();
    endtask

    function automatic int model_out();
        int acc = 0;
        for (int i = 0; i < TAPS; i++) begin
            acc = acc + int'(m_coef[i]) * int'(m_tap[i]);
`ifdef FIR_TAP_SEQUENCER_SAT_EN
            if (acc > ACC_MAX) acc = ACC_MAX;
`else
            acc = acc % (ACC_MAX + 1);
`endif
        end
        return acc;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_cfg_err"}, int'(cfg_err), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        model_reset();
        reset = 1'b1;
        @(negedge clock);
        check_idle("reset");
        check("reset_out_data", int'(out_data), 0);
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic drive_sample(input logic [DATA_W-1:0] v, input logic we,
                                input logic [ADDR_W-1:0] a, input logic [COEF_W-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        x        = v;
        cfg_we   = we;
        cfg_addr = a;
        cfg_data = d;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("accept_wait", int'(in_ready), 1);
        if (we) m_coef[a] = d;
        for (int i = TAPS - 1; i > 0; i--) m_tap[i] = m_tap[i-1];
        m_tap[0] = v;
        sb.push_back(model_out());
        @(negedge clock);
        accept_cyc = cyc;
        in_valid   = 1'b0;
        cfg_we     = 1'b0;
    endtask

    task automatic wait_output(input string tag);
        int n = 0;
        int exp_v;
        while (!out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_latency"}, cyc - accept_cyc, TAPS);
        exp_v = (sb.size() > 0) ? sb.pop_front() : -1;
        check({tag, "_out_data"}, int'(out_data), exp_v);
        last_exp = exp_v;
    endtask

    task automatic release_output(input string tag);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, int'(out_valid), 0);
        check({tag, "_idle_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        @(negedge clock);

        // Asynchronous reset state is visible before any clock edge is released.
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_in_ready", int'(in_ready), 1);
        do_reset();

        // Basic sequence with default coefficients: 2, 7, 14, then 6 (wrap) or 15 (saturate).
        drive_sample(2'd2, 1'b0, '0, '0);
        check("accum_busy", int'(busy), 1);
        check("accum_in_ready", int'(in_ready), 0);
        wait_output("s1");
        check("s1_value", last_exp, 2);
        release_output("s1");
        drive_sample(2'd3, 1'b0, '0, '0);
        wait_output("s2");
        check("s2_value", last_exp, 7);
        release_output("s2");
        drive_sample(2'd2, 1'b0, '0, '0);
        wait_output("s3");
        check("s3_value", last_exp, 14);
        release_output("s3");
        drive_sample(2'd1, 1'b0, '0, '0);
        wait_output("s4");
`ifdef FIR_TAP_SEQUENCER_SAT_EN
        check("s4_value", last_exp, 15);
`else
        check("s4_value", last_exp, 6);
`endif
        release_output("s4");

        // Backpressure: result held while the next sample waits at the input.
        drive_sample(2'd2, 1'b0, '0, '0);
        wait_output("bp");
        in_valid = 1'b1;
        x        = 2'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_data", int'(out_data), last_exp);
            check("bp_hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        drive_sample(2'd3, 1'b0, '0, '0);
        wait_output("bp_next");
        release_output("bp_next");

        // Config write while busy is dropped and flagged for one cycle.
        drive_sample(2'd1, 1'b0, '0, '0);
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_data = 4'd5;
        @(negedge clock);
        cfg_we = 1'b0;
        check("cfg_busy_err", int'(cfg_err), 1);
        @(negedge clock);
        check("cfg_busy_err_clear", int'(cfg_err), 0);
        wait_output("cfg_busy");
        release_output("cfg_busy");
        drive_sample(2'd0, 1'b0, '0, '0);
        wait_output("cfg_kept");
        release_output("cfg_kept");

        // Config write in idle after a fresh reset: coef[0]=5, x=2 -> 10.
        do_reset();
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_data = 4'd5;
        m_coef[0] = 4'd5;
        @(negedge clock);
        cfg_we = 1'b0;
        check("cfg_idle_no_err", int'(cfg_err), 0);
        drive_sample(2'd2, 1'b0, '0, '0);
        wait_output("cfg_idle");
        check("cfg_idle_value", last_exp, 10);
        release_output("cfg_idle");

        // Reset mid-accumulation at k=3 discards the partial result.
        drive_sample(2'd3, 1'b0, '0, '0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_busy", int'(busy), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_idle("midrst_release");
        drive_sample(2'd2, 1'b0, '0, '0);
        wait_output("midrst_after");
        check("midrst_after_value", last_exp, 2);
        release_output("midrst_after");

        // Config write coinciding with accept: new coef[0]=3 used immediately -> 6.
        do_reset();
        drive_sample(2'd2, 1'b1, '0, 4'd3);
        check("simul_no_err", int'(cfg_err), 0);
        wait_output("simul");
        check("simul_value", last_exp, 6);
        release_output("simul");

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Time-multiplexed FIR controller: holds a TAPS-deep sample delay line and a per-tap coefficient table.
- Sequences one shared multiply-accumulate step per clock over all taps, then presents one filtered output per input sample.
- Valid/ready on both sides; coefficient table reprogrammed through a config write port while idle.
- Sits between the sample source and the downstream consumer, in place of a fully unrolled tap/adder chain.

Parameters:
- DATA_W, 2: input sample width (unsigned).
- COEF_W, 4: coefficient width (unsigned).
- TAPS, 8: number of taps; power of two, at least 2.
- ACC_W, 4: accumulator/output width; arithmetic is modulo 2^ACC_W.
- ADDR_W, 3: log2(TAPS).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- in_valid  input  1  sample x is offered
- in_ready  output  1  block accepts a sample this cycle
- x  input  DATA_W  input sample
- out_valid  output  1  out_data holds a finished result
- out_ready  input  1  consumer takes the result
- out_data  output  ACC_W  filtered output
- cfg_we  input  1  coefficient write strobe
- cfg_addr  input  ADDR_W  tap index to write
- cfg_data  input  COEF_W  coefficient value
- cfg_err  output  1  one-cycle pulse: config write rejected
- busy  output  1  high in ACCUM and DONE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; delay line all 0; acc=0; tap index k=0; out_valid=0; out_data=0; cfg_err=0; coef[i]=i+1 (1..8 for TAPS=8).
- Reset takes effect immediately, even mid-computation. The partial result is discarded; no out_valid is produced for it.
- States:
  - IDLE: in_ready=1, busy=0.
  - ACCUM: in_ready=0, busy=1.
  - DONE: in_ready=0, busy=1, out_valid=1.
- IDLE to ACCUM on in_valid at an edge (the accept edge):
  - tap[0]<=x; tap[i]<=tap[i-1]; the oldest sample drops.
  - acc<=0; k<=0.
- ACCUM: each edge adds acc<=acc+coef[k]*tap[k] (mod 2^ACC_W) and increments k.
  - The product is computed at full width (DATA_W+COEF_W), then added modulo 2^ACC_W.
  - On the edge processing k=TAPS-1: out_data<=final sum, out_valid<=1, state to DONE.
- Latency: out_valid rises exactly TAPS edges after the accept edge (8 cycles by default).
- DONE: out_data and out_valid hold stable until out_ready=1 at an edge; then out_valid<=0 and state to IDLE.
  - in_valid is ignored in DONE and ACCUM (in_ready=0); the source must hold the sample.
- Minimum sample period: TAPS+2 cycles.
- Config write:
  - In IDLE, cfg_we at an edge writes coef[cfg_addr]<=cfg_data.
  - If cfg_we coincides with an accept edge, the write still lands, and the computation started on that edge uses the new coefficient.
  - cfg_we in ACCUM or DONE: write dropped, coefficients unchanged, cfg_err=1 for exactly the next cycle.
- The delay line is not cleared between samples; only reset clears it.

Optional Feature:
- Macro: FIR_TAP_SEQUENCER_SAT_EN
- Defined: each accumulate step saturates. If acc plus the full-width product exceeds 2^ACC_W-1, acc<=2^ACC_W-1 and stays there for the rest of that sample. out_data is clamped accordingly.
- Undefined: plain modulo-2^ACC_W wrap as specified above. No saturation logic is present.

Test Plan:
- Reset with default coefs; send x=2, then 3, then 2 (each after the prior output is taken, out_ready=1) -> out_data=2, then 7, then 14. out_valid rises 8 cycles after each accept edge.
- Continue with x=1 (taps 1,2,3,2) -> out_data=6 (22 mod 16). With FIR_TAP_SEQUENCER_SAT_EN defined -> out_data=15.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with x=3 -> out_data stable, in_ready=0, delay line unchanged. The sample is accepted only after out_ready=1 has returned the block to IDLE.
- Config while busy: cfg_we=1 with addr 0 and data 5 during ACCUM -> cfg_err pulses 1 cycle, coef[0] stays 1. Same write in IDLE then x=2 (fresh reset) -> out_data=10.
- Reset mid-ACCUM: drive reset=0 at k=3 -> out_valid=0, out_data=0 and busy=0 immediately. After release, x=2 -> out_data=2 (delay line and coefs restored).
- Simultaneous cfg_we (addr 0, data 3) and in_valid with x=2 in IDLE after reset -> out_data=6.
